fifo_dp_ctl: RTL and testbench

FIFO_DP_CTL -- requirements
Module: fifo_dp_ctl

---
 rtl/fifo_dp_ctl.sv | 160 ++++++++++++++++
 tb/tb_fifo_dp_ctl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_dp_ctl.sv
// First-word-fall-through FIFO controller around a dual-port RAM.
// Prefetches RAM words into a 2-entry registered staging buffer.
module ram_dp #(
    parameter int unsigned DATAWIDTH = 9,
    parameter int unsigned ADDRWIDTH = 9
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH-1:0] wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic [DATAWIDTH-1:0] rd_data
);
    logic [DATAWIDTH-1:0] mem_q [0:(1<<ADDRWIDTH)-1];
    logic [DATAWIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

module fifo_dp_ctl #(
    parameter int unsigned DATAWIDTH = 9,
    parameter int unsigned ADDRWIDTH = 9
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 clear,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDRWIDTH:0]   count
);
    localparam logic [ADDRWIDTH:0]   DEPTH   = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [ADDRWIDTH:0]   CNT_ONE = {{ADDRWIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRWIDTH-1:0] PTR_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};

    logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [ADDRWIDTH:0]   count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [1:0]           stg_vld_q, stg_vld_d;
    logic [DATAWIDTH-1:0] stg0_q, stg0_d;
    logic [DATAWIDTH-1:0] stg1_q, stg1_d;

    logic                 push;
    logic                 pop;
    logic                 rd_issue;
    logic [1:0]           occ;
    logic [DATAWIDTH-1:0] ram_rd_data;

    ram_dp #(
        .DATAWIDTH(DATAWIDTH),
        .ADDRWIDTH(ADDRWIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push & ~clear),
        .wr_addr(wr_ptr_q),
        .wr_data(in_data),
        .rd_en  (rd_issue),
        .rd_addr(rd_ptr_q),
        .rd_data(ram_rd_data)
    );

    always_comb begin
        push = in_valid & in_ready_q;
        pop  = stg_vld_q[0] & out_ready;
        // staging slots that stay committed after this edge's pop
        occ = {1'b0, stg_vld_q[0]} + {1'b0, stg_vld_q[1]}
            + {1'b0, rd_vld_q} - {1'b0, pop};
        rd_issue = (ram_cnt_q != '0) && (occ < 2'd2) && !clear;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        count_d    = count_q;
        rd_vld_d   = rd_issue;
        stg_vld_d  = stg_vld_q;
        stg0_d     = stg0_q;
        stg1_d     = stg1_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_issue) rd_ptr_d = rd_ptr_q + PTR_ONE;

        unique case ({push, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (pop) begin
            stg0_d    = stg1_q;
            stg_vld_d = {1'b0, stg_vld_q[1]};
        end
        if (rd_vld_q) begin
            if (!stg_vld_d[0]) begin
                stg0_d       = ram_rd_data;
                stg_vld_d[0] = 1'b1;
            end else begin
                stg1_d       = ram_rd_data;
                stg_vld_d[1] = 1'b1;
            end
        end

        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            count_d   = '0;
            rd_vld_d  = 1'b0;
            stg_vld_d = 2'b00;
        end

        in_ready_d = (count_d != DEPTH);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            stg_vld_q  <= 2'b00;
            stg0_q     <= '0;
            stg1_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            rd_vld_q   <= rd_vld_d;
            stg_vld_q  <= stg_vld_d;
            stg0_q     <= stg0_d;
            stg1_q     <= stg1_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = stg_vld_q[0];
    assign out_data  = stg0_q;
    assign count     = count_q;
endmodule

// File: tb/tb_fifo_dp_ctl.sv
// Bench for fifo_dp_ctl: vector table, directed corners and
// randomized traffic against a queue-based reference model.
module tb_fifo_dp_ctl;
    logic       clk = 1'b0;
    logic       reset_l;
    logic       clear;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;

    fifo_dp_ctl #(
        .DATAWIDTH(9),
        .ADDRWIDTH(4)
    ) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [8:0] id;
        logic       ordy;
        logic       ov;
        logic [8:0] od;
        logic [4:0] cnt;
        logic       ir;
    } vec_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [8:0] mq[$];
    int         ma[$];
    bit         last_pop;
    logic [8:0] last_pop_data;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // one clock edge; reference model is an ordered queue of held words
    task automatic step();
        bit         pu, po, cl;
        logic [8:0] pd, od;
        pu = in_valid && in_ready;
        po = out_valid && out_ready;
        cl = clear;
        pd = in_data;
        od = out_data;
        @(posedge clk);
        #1;
        cyc++;
        last_pop = po && !cl;
        last_pop_data = od;
        if (cl) begin
            mq.delete();
            ma.delete();
        end else begin
            if (po && mq.size() > 0) begin
                void'(mq.pop_front());
                void'(ma.pop_front());
            end
            if (pu) begin
                mq.push_back(pd);
                ma.push_back(cyc);
            end
        end
        chk("count", int'(count), mq.size());
        chk("in_ready", int'(in_ready), int'(mq.size() != 16));
        if (mq.size() == 0) begin
            chk("valid_when_empty", int'(out_valid), 0);
        end else begin
            if (out_valid) chk("head_data", int'(out_data), int'(mq[0]));
            if (cyc - ma[0] >= 2) chk("valid_latency", int'(out_valid), 1);
        end
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && count != 0; i++) step();
        step();
        chk(name, int'(count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   k;
        int   npop;

        tbl[0] = '{1'b1, 9'h1A5, 1'b1, 1'b0, 9'h000, 5'd1, 1'b1};
        tbl[1] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 5'd1, 1'b1};
        tbl[2] = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h1A5, 5'd1, 1'b1};
        tbl[3] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 5'd0, 1'b1};
        tbl[4] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 5'd0, 1'b1};

        reset_l   = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        step();

        // single word latency
        for (int i = 0; i < 5; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            step();
            chk("tbl_out_valid", int'(out_valid), int'(tbl[i].ov));
            chk("tbl_count", int'(count), int'(tbl[i].cnt));
            chk("tbl_in_ready", int'(in_ready), int'(tbl[i].ir));
            if (tbl[i].ov) chk("tbl_out_data", int'(out_data), int'(tbl[i].od));
        end

        // fill to full, extra push refused, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 9'(i);
            step();
        end
        chk("full_count", int'(count), 16);
        chk("full_in_ready", int'(in_ready), 0);
        in_data = 9'h010;
        step();
        chk("full_ignored", int'(count), 16);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 60 && k < 16; i++) begin
            step();
            if (last_pop) begin
                chk("fill_order", int'(last_pop_data), k);
                k++;
            end
        end
        chk("fill_pops", k, 16);
        step();
        chk("fill_empty", int'(count), 0);

        // streaming: push every cycle, pop whenever valid
        in_valid  = 1'b1;
        out_ready = 1'b1;
        npop = 0;
        for (int i = 0; i < 105; i++) begin
            in_data = 9'(i + 32);
            step();
            if (last_pop) npop++;
            if (i >= 2) chk("stream_count", int'(count), 3);
        end
        chk("stream_pops", npop, 102);
        drain("stream_drain");

        // random traffic with backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom % 10) < 7;
            in_data   = 9'($urandom);
            out_ready = $urandom % 2;
            step();
        end
        drain("rand_drain");

        // clear with 5 words held and a simultaneous push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 9'(9'h100 + i);
            step();
        end
        clear   = 1'b1;
        in_data = 9'h055;
        step();
        clear = 1'b0;
        chk("clear_count", int'(count), 0);
        chk("clear_out_valid", int'(out_valid), 0);
        in_data = 9'h077;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        npop = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_pop) begin
                npop++;
                chk("clear_word", int'(last_pop_data), 9'h077);
            end
        end
        chk("clear_pops", npop, 1);

        // async reset with 8 words held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 9'(9'h0A0 + i);
            step();
        end
        in_valid = 1'b0;
        #3;
        reset_l = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        mq.delete();
        ma.delete();
        #2;
        reset_l   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("arst_no_word", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
